// File: rtl/pc_ras_if.sv
// pc_ras decoder-side bus.
// Carries op/cond/target in and PC/RAS status out.
interface pc_ras_if #(
   parameter int Psize = 6,
   parameter int Depth = 4
);
   localparam int DW = $clog2(Depth + 1);

   logic             stall;
   logic [2:0]       op;
   logic             cond;
   logic [Psize-1:0] target;
   logic [Psize-1:0] PCout;
   logic [DW-1:0]    ras_depth;
   logic             ras_empty;
   logic             ras_full;
   logic             ras_err;

   modport master (
      output stall, op, cond, target,
      input  PCout, ras_depth,
      input  ras_empty, ras_full, ras_err
   );

   modport slave (
      input  stall, op, cond, target,
      output PCout, ras_depth,
      output ras_empty, ras_full, ras_err
   );
endinterface

// File: rtl/pc_ras.sv
// picoMIPS program counter with return-address stack.
// One adder serves incr, branch and push address.
module pc_ras #(
   parameter int               Psize     = 6,
   parameter int               Depth     = 4,
   parameter logic [Psize-1:0] ResetAddr = '0
) (
   input logic  clk,
   input logic  reset,
   pc_ras_if.slave bus
);
   localparam int DW = $clog2(Depth + 1);
   localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

   localparam logic [2:0] OP_INCR = 3'b001;
   localparam logic [2:0] OP_REL  = 3'b010;
   localparam logic [2:0] OP_ABS  = 3'b011;
   localparam logic [2:0] OP_CALL = 3'b100;
   localparam logic [2:0] OP_RET  = 3'b101;

   logic [Psize-1:0] pc, pc_n;
   logic [Psize-1:0] addend, sum;
   logic [DW-1:0]    depth, depth_n;
   logic             err, err_n;
   logic             push;
   logic             full, empty;
   logic [AW-1:0]    wr_idx, rd_idx;
   logic [Psize-1:0] stk [Depth];

   assign full   = (depth == DW'(Depth));
   assign empty  = (depth == '0);
   assign wr_idx = AW'(depth);
   assign rd_idx = AW'(depth - DW'(1));

   // Only a taken relative branch replaces the +1.
   assign addend = (bus.op == OP_REL && bus.cond)
                 ? bus.target : Psize'(1);
   assign sum    = pc + addend;

   always_comb begin
      pc_n    = pc;
      depth_n = depth;
      err_n   = err;
      push    = 1'b0;
      if (!bus.stall) begin
         case (bus.op)
            OP_INCR: pc_n = sum;
            OP_REL:  pc_n = sum;
            OP_ABS:  pc_n = bus.cond ? bus.target : sum;
            OP_CALL: begin
               pc_n = bus.target;
               if (full) begin
                  err_n = 1'b1;
               end else begin
                  push    = 1'b1;
                  depth_n = depth + DW'(1);
               end
            end
            OP_RET: begin
               if (empty) begin
                  pc_n  = sum;
                  err_n = 1'b1;
               end else begin
                  pc_n    = stk[rd_idx];
                  depth_n = depth - DW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc    <= ResetAddr;
         depth <= '0;
         err   <= 1'b0;
      end else begin
         pc    <= pc_n;
         depth <= depth_n;
         err   <= err_n;
      end
   end

   // Stack storage needs no reset; depth marks valid entries.
   always_ff @(posedge clk) begin
      if (push) stk[wr_idx] <= sum;
   end

   assign bus.PCout     = pc;
   assign bus.ras_depth = depth;
   assign bus.ras_empty = empty;
   assign bus.ras_full  = full;
   assign bus.ras_err   = err;
endmodule

// File: tb/tb_pc_ras.sv
// Directed testbench for pc_ras.
// Psize=6, Depth=4, ResetAddr=0.
module tb_pc_ras;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   pc_ras_if #(.Psize(6), .Depth(4)) bus ();

   pc_ras #(
      .Psize(6), .Depth(4), .ResetAddr(6'd0)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [2:0] o,
                        input logic c,
                        input logic [5:0] t);
      bus.op = o;
      bus.cond = c;
      bus.target = t;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      bus.stall = 1'b0;
      drive(3'b000, 1'b0, 6'd0);
      reset = 1'b1;
      #3;
      total++;
      if (bus.PCout !== 6'd0) begin
         bad++; $display("FAIL rst_pc got=%0d exp=0", bus.PCout);
      end
      total++;
      if (bus.ras_depth !== 3'd0) begin
         bad++; $display("FAIL rst_depth got=%0d exp=0", bus.ras_depth);
      end
      total++;
      if ({bus.ras_empty, bus.ras_full, bus.ras_err} !== 3'b100) begin
         bad++;
         $display("FAIL rst_flags got=%b exp=100",
                  {bus.ras_empty, bus.ras_full, bus.ras_err});
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_incr_stall();
      logic [5:0] exp;
      drive(3'b001, 1'b0, 6'd0);
      for (int i = 1; i <= 3; i++) begin
         step();
         exp = 6'(i);
         total++;
         if (bus.PCout !== exp) begin
            bad++; $display("FAIL incr%0d got=%0d exp=%0d", i, bus.PCout, exp);
         end
      end
      bus.stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if (bus.PCout !== 6'd3) begin
            bad++; $display("FAIL stall%0d got=%0d exp=3", i, bus.PCout);
         end
      end
      bus.stall = 1'b0;
      step();
      total++;
      if (bus.PCout !== 6'd4) begin
         bad++; $display("FAIL unstall got=%0d exp=4", bus.PCout);
      end
   endtask

   task automatic test_branch();
      drive(3'b011, 1'b1, 6'd10); step();
      drive(3'b010, 1'b1, 6'b111101); step();
      total++;
      if (bus.PCout !== 6'd7) begin
         bad++; $display("FAIL rel_neg got=%0d exp=7", bus.PCout);
      end
      drive(3'b011, 1'b1, 6'd10); step();
      drive(3'b010, 1'b0, 6'b111101); step();
      total++;
      if (bus.PCout !== 6'd11) begin
         bad++; $display("FAIL rel_nt got=%0d exp=11", bus.PCout);
      end
      drive(3'b011, 1'b1, 6'd62); step();
      drive(3'b010, 1'b1, 6'd5); step();
      total++;
      if (bus.PCout !== 6'd3) begin
         bad++; $display("FAIL rel_wrap got=%0d exp=3", bus.PCout);
      end
      total++;
      if (bus.ras_err !== 1'b0) begin
         bad++; $display("FAIL wrap_err got=%b exp=0", bus.ras_err);
      end
      drive(3'b110, 1'b1, 6'd20); step();
      total++;
      if (bus.PCout !== 6'd3) begin
         bad++; $display("FAIL op110 got=%0d exp=3", bus.PCout);
      end
   endtask

   task automatic test_call_ret();
      drive(3'b011, 1'b1, 6'd5); step();
      drive(3'b100, 1'b0, 6'd40); step();
      total++;
      if ({bus.PCout, bus.ras_depth, bus.ras_empty} !== {6'd40, 3'd1, 1'b0}) begin
         bad++;
         $display("FAIL call pc=%0d d=%0d e=%b exp 40/1/0",
                  bus.PCout, bus.ras_depth, bus.ras_empty);
      end
      drive(3'b101, 1'b0, 6'd0); step();
      total++;
      if ({bus.PCout, bus.ras_depth, bus.ras_empty} !== {6'd6, 3'd0, 1'b1}) begin
         bad++;
         $display("FAIL ret pc=%0d d=%0d e=%b exp 6/0/1",
                  bus.PCout, bus.ras_depth, bus.ras_empty);
      end
      drive(3'b011, 1'b0, 6'd50); step();
      total++;
      if (bus.PCout !== 6'd7) begin
         bad++; $display("FAIL abs_nt got=%0d exp=7", bus.PCout);
      end
   endtask

   task automatic test_nested();
      logic [5:0] tg;
      logic [5:0] rexp [4];
      logic [2:0] dexp;
      rexp[0] = 6'd31; rexp[1] = 6'd21;
      rexp[2] = 6'd11; rexp[3] = 6'd2;
      do_reset();
      drive(3'b011, 1'b1, 6'd1); step();
      for (int i = 1; i <= 4; i++) begin
         tg = 6'(10 * i);
         dexp = 3'(i);
         drive(3'b100, 1'b0, tg); step();
         total++;
         if ({bus.PCout, bus.ras_depth} !== {tg, dexp}) begin
            bad++;
            $display("FAIL ncall%0d pc=%0d d=%0d exp %0d/%0d",
                     i, bus.PCout, bus.ras_depth, tg, dexp);
         end
      end
      total++;
      if ({bus.ras_full, bus.ras_err} !== 2'b10) begin
         bad++;
         $display("FAIL full got=%b exp=10", {bus.ras_full, bus.ras_err});
      end
      drive(3'b100, 1'b0, 6'd50); step();
      total++;
      if ({bus.PCout, bus.ras_depth, bus.ras_err} !== {6'd50, 3'd4, 1'b1}) begin
         bad++;
         $display("FAIL ovf pc=%0d d=%0d err=%b exp 50/4/1",
                  bus.PCout, bus.ras_depth, bus.ras_err);
      end
      drive(3'b101, 1'b0, 6'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if (bus.PCout !== rexp[i]) begin
            bad++;
            $display("FAIL nret%0d got=%0d exp=%0d", i, bus.PCout, rexp[i]);
         end
      end
      total++;
      if ({bus.ras_depth, bus.ras_empty} !== {3'd0, 1'b1}) begin
         bad++;
         $display("FAIL nempty d=%0d e=%b exp 0/1",
                  bus.ras_depth, bus.ras_empty);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      drive(3'b011, 1'b1, 6'd20); step();
      drive(3'b101, 1'b0, 6'd0); step();
      total++;
      if ({bus.PCout, bus.ras_depth, bus.ras_err} !== {6'd21, 3'd0, 1'b1}) begin
         bad++;
         $display("FAIL unf pc=%0d d=%0d err=%b exp 21/0/1",
                  bus.PCout, bus.ras_depth, bus.ras_err);
      end
      drive(3'b001, 1'b0, 6'd0); step(); step();
      total++;
      if ({bus.PCout, bus.ras_err} !== {6'd23, 1'b1}) begin
         bad++;
         $display("FAIL sticky pc=%0d err=%b exp 23/1",
                  bus.PCout, bus.ras_err);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(3'b011, 1'b1, 6'd8); step();
      drive(3'b100, 1'b0, 6'd30); step();
      bus.stall = 1'b1;
      drive(3'b100, 1'b1, 6'd60); step();
      total++;
      if ({bus.PCout, bus.ras_depth} !== {6'd30, 3'd1}) begin
         bad++;
         $display("FAIL stcall pc=%0d d=%0d exp 30/1",
                  bus.PCout, bus.ras_depth);
      end
      bus.stall = 1'b0;
      drive(3'b101, 1'b0, 6'd0); step();
      total++;
      if ({bus.PCout, bus.ras_depth, bus.ras_err} !== {6'd9, 3'd0, 1'b0}) begin
         bad++;
         $display("FAIL b2b pc=%0d d=%0d err=%b exp 9/0/0",
                  bus.PCout, bus.ras_depth, bus.ras_err);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(3'b100, 1'b0, 6'd10); step();
      drive(3'b100, 1'b0, 6'd32); step();
      drive(3'b001, 1'b0, 6'd0); step();
      total++;
      if ({bus.PCout, bus.ras_depth} !== {6'd33, 3'd2}) begin
         bad++;
         $display("FAIL pre_ar pc=%0d d=%0d exp 33/2",
                  bus.PCout, bus.ras_depth);
      end
      #3;
      reset = 1'b1;
      #1;
      total++;
      if ({bus.PCout, bus.ras_depth, bus.ras_err, bus.ras_empty}
          !== {6'd0, 3'd0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL async pc=%0d d=%0d err=%b e=%b exp 0/0/0/1",
                  bus.PCout, bus.ras_depth, bus.ras_err, bus.ras_empty);
      end
      #1;
      reset = 1'b0;
      step();
      total++;
      if (bus.PCout !== 6'd1) begin
         bad++; $display("FAIL post_ar got=%0d exp=1", bus.PCout);
      end
   endtask

   initial begin
      test_reset();
      test_incr_stall();
      test_branch();
      test_call_ret();
      test_nested();
      test_underflow();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
